gray_bin_serial_ctrl: RTL

//  Frame sequencer for the serial Gray->binary datapath (5-bit PISO -> Gray->binary FSM -> 5-bit SIPO).

---
 rtl/gray_bin_serial_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gray_bin_serial_ctrl.sv
// Frame sequencer for the serial Gray->binary datapath.
// Loads one Gray word per handshake into the PISO, waits out the pipeline, returns the SIPO word.
//
// Ports:
//   clk        rising-edge clock shared with the datapath
//   rst_n      synchronous active-low reset
//   in_valid   requester offers a Gray word on in_data
//   in_ready   controller accepts in_data this cycle (IDLE only)
//   in_data    Gray-coded word, MSB first on the serial line
//   dp_shift   datapath control: 0 = parallel load, 1 = shift
//   dp_inp     datapath parallel input (held word)
//   dp_out     datapath SIPO output
//   out_valid  out_data holds a converted binary word
//   out_ready  consumer takes out_data
//   out_data   captured dp_out
//   busy       high in any state other than IDLE
module gray_bin_serial_ctrl #(
    parameter int WIDTH      = 5,
    parameter int DP_LAT     = 6,
    parameter int LOAD_PHASE = 0,
    parameter int FLUSH_CYC  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             dp_shift,
    output logic [WIDTH-1:0] dp_inp,
    input  logic [WIDTH-1:0] dp_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW = $clog2(DP_LAT + 1);
    localparam int FW = $clog2(FLUSH_CYC + 1);

    localparam logic [PW-1:0] PH_LAST    = PW'(WIDTH - 1);
    // LOAD must occupy the cycle whose phase is LOAD_PHASE, so the
    // decision to enter LOAD is taken one phase earlier.
    localparam logic [PW-1:0] PH_PRE     = PW'((LOAD_PHASE + WIDTH - 1) % WIDTH);
    localparam logic [LW-1:0] LAT_LAST   = LW'(DP_LAT);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_WAITP,
        S_LOAD,
        S_DRAIN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [PW-1:0]     phase_q,     phase_d;
    logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [LW-1:0]     lat_cnt_q,   lat_cnt_d;
    logic [WIDTH-1:0]  hold_q,      hold_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;

    // Free-running phase, aligned with the datapath FSM period.
    always_comb begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_LAST) begin
            phase_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_FLUSH: begin
                // Shift the datapath empty before accepting any frame.
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    hold_d = in_data;
                    if (phase_q == PH_PRE) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_WAITP;
                    end
                end
            end
            S_WAITP: begin
                if (phase_q == PH_PRE) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                lat_cnt_d = LW'(1);
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = S_CAPT;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_CAPT: begin
                // dp_out holds the complete word during this cycle only.
                out_data_d  = dp_out;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FLUSH;
            phase_q     <= '0;
            flush_cnt_q <= '0;
            lat_cnt_q   <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            flush_cnt_q <= flush_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // All handshake outputs decode from registered state only.
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign dp_shift  = (state_q != S_LOAD);
    assign dp_inp    = hold_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
